// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-fetch / write-back stage:
// opcodes, FSM state encoding and default widths.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // Only add/sub produce a meaningful overflow flag.
    function automatic logic op_sets_of(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two async read ports plus a debug read port, one sync write.
// R0 is hardwired to zero on every read port and never written.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [ADDR_W-1:0] raddr_d_i,
    output logic [DATA_W-1:0] rdata_d_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
    assign rdata_d_o = (raddr_d_i == '0) ? '0 : mem_q[raddr_d_i];

endmodule

// File: rtl/alu_regfile_stage.sv
// Operand-fetch / write-back stage around an external combinational ALU.
// Accepts one op every two cycles, writes F back and keeps sticky flags.
module alu_regfile_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [ADDR_W-1:0] Addr_B,
    input  logic [ADDR_W-1:0] Addr_W,
    input  logic [2:0]        Op_In,
    input  logic              Init_We,
    input  logic [ADDR_W-1:0] Init_Addr,
    input  logic [DATA_W-1:0] Init_Data,
    input  logic [ADDR_W-1:0] Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        ALU_OP,
    input  logic [DATA_W-1:0] F,
    input  logic              ZF,
    input  logic              OF,
    output logic              Flag_ZF,
    output logic              Flag_OF,
    output logic              done
);

    state_e            state_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              zf_q, of_q, done_q;

    logic [DATA_W-1:0] rd_a, rd_b;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_d;
    logic              accept;

    // Init preload has priority over acceptance and is only honoured in IDLE.
    assign in_ready = (state_q == ST_IDLE) && !Init_We;
    assign accept   = in_valid && in_ready;

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = Init_Addr;
        rf_wdata_d = Init_Data;
        if (state_q == ST_EXEC) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = waddr_q;
            rf_wdata_d = F;
        end else if (Init_We) begin
            rf_we_d = 1'b1;
        end
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we_d),
        .waddr_i   (rf_waddr_d),
        .wdata_i   (rf_wdata_d),
        .raddr_a_i (Addr_A),
        .rdata_a_o (rd_a),
        .raddr_b_i (Addr_B),
        .rdata_b_o (rd_b),
        .raddr_d_i (Dbg_Addr),
        .rdata_d_o (Dbg_Data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            waddr_q <= '0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= rd_a;
                        b_q     <= rd_b;
                        op_q    <= Op_In;
                        waddr_q <= Addr_W;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU has settled on the held operands; retire the op.
                    zf_q <= ZF;
                    if (op_sets_of(op_q)) begin
                        of_q <= OF;
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign ALU_OP  = op_q;
    assign Flag_ZF = zf_q;
    assign Flag_OF = of_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alu_regfile_stage.sv
// Directed bench for alu_regfile_stage with a behavioural 32-bit ALU
// closing the loop from A/B/ALU_OP back to F/ZF/OF.
module tb_alu_regfile_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  Addr_A = '0, Addr_B = '0, Addr_W = '0;
    logic [2:0]  Op_In = '0;
    logic        Init_We = 1'b0;
    logic [4:0]  Init_Addr = '0;
    logic [31:0] Init_Data = '0;
    logic [4:0]  Dbg_Addr = '0;
    logic [31:0] Dbg_Data;
    logic [31:0] A, B;
    logic [2:0]  ALU_OP;
    logic [31:0] F;
    logic        ZF, OF;
    logic        Flag_ZF, Flag_OF, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_regfile_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Addr_A    (Addr_A),
        .Addr_B    (Addr_B),
        .Addr_W    (Addr_W),
        .Op_In     (Op_In),
        .Init_We   (Init_We),
        .Init_Addr (Init_Addr),
        .Init_Data (Init_Data),
        .Dbg_Addr  (Dbg_Addr),
        .Dbg_Data  (Dbg_Data),
        .A         (A),
        .B         (B),
        .ALU_OP    (ALU_OP),
        .F         (F),
        .ZF        (ZF),
        .OF        (OF),
        .Flag_ZF   (Flag_ZF),
        .Flag_OF   (Flag_OF),
        .done      (done)
    );

    // Behavioural ALU: and, or, xor, nor, add, sub, slt, B<<A[4:0]
    always_comb begin
        F  = '0;
        OF = 1'b0;
        case (ALU_OP)
            3'b000: F = A & B;
            3'b001: F = A | B;
            3'b010: F = A ^ B;
            3'b011: F = ~(A | B);
            3'b100: begin
                F  = A + B;
                OF = (A[31] == B[31]) && (F[31] != A[31]);
            end
            3'b101: begin
                F  = A - B;
                OF = (A[31] != B[31]) && (F[31] != A[31]);
            end
            3'b110: F = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            default: F = B << A[4:0];
        endcase
        ZF = (F == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        Dbg_Addr = addr;
        #1;
        check(tag, Dbg_Data, exp);
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        Init_We   = 1'b1;
        Init_Addr = addr;
        Init_Data = data;
        #1;
        check("init_blocks_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        Init_We = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] w,
                          input logic [31:0] ea, input logic [31:0] eb);
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        Op_In    = op;
        Addr_A   = a;
        Addr_B   = b;
        Addr_W   = w;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".A"}, A, ea);
        check({tag, ".B"}, B, eb);
        check({tag, ".op"}, {29'd0, ALU_OP}, {29'd0, op});
        check({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
        check({tag, ".done_lo"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        check({tag, ".done_hi"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", {31'd0, in_ready}, 32'd1);
        check("rst.A", A, 32'd0);
        check("rst.B", B, 32'd0);
        check("rst.op", {29'd0, ALU_OP}, 32'd0);
        check("rst.zf", {31'd0, Flag_ZF}, 32'd0);
        check("rst.of", {31'd0, Flag_OF}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check_reg("rst.reg", i[4:0], 32'd0);
        end

        // 2. add R1,R2 -> R3
        preload(5'd1, 32'h0000_FFFF);
        preload(5'd2, 32'h0000_FFFF);
        preload(5'd0, 32'hDEAD_BEEF);
        check_reg("r0_init_ignored", 5'd0, 32'd0);
        run_op("add1", 3'b100, 5'd1, 5'd2, 5'd3, 32'h0000_FFFF, 32'h0000_FFFF);
        check("add1.zf", {31'd0, Flag_ZF}, 32'd0);
        check("add1.of", {31'd0, Flag_OF}, 32'd0);
        check_reg("add1.r3", 5'd3, 32'h0001_FFFE);
        @(negedge clk);
        check("add1.done_pulse", {31'd0, done}, 32'd0);

        // 3. overflowing add, then and with flag OF held
        preload(5'd4, 32'h7FFF_0000);
        run_op("add2", 3'b100, 5'd4, 5'd4, 5'd5, 32'h7FFF_0000, 32'h7FFF_0000);
        check_reg("add2.r5", 5'd5, 32'hFFFE_0000);
        check("add2.of", {31'd0, Flag_OF}, 32'd1);
        check("add2.zf", {31'd0, Flag_ZF}, 32'd0);
        run_op("and", 3'b000, 5'd4, 5'd0, 5'd6, 32'h7FFF_0000, 32'd0);
        check_reg("and.r6", 5'd6, 32'd0);
        check("and.zf", {31'd0, Flag_ZF}, 32'd1);
        check("and.of_held", {31'd0, Flag_OF}, 32'd1);

        // 4. sub into R0
        run_op("sub", 3'b101, 5'd1, 5'd1, 5'd0, 32'h0000_FFFF, 32'h0000_FFFF);
        check_reg("sub.r0", 5'd0, 32'd0);
        check("sub.zf", {31'd0, Flag_ZF}, 32'd1);
        check("sub.of", {31'd0, Flag_OF}, 32'd0);

        // 5. back-to-back with in_valid held high
        preload(5'd8, 32'd1);
        @(negedge clk);
        check("b2b.ready0", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        Op_In = 3'b001; Addr_A = 5'd1; Addr_B = 5'd0; Addr_W = 5'd7;
        @(negedge clk);
        check("b2b.ready1", {31'd0, in_ready}, 32'd0);
        check("b2b.or_A", A, 32'h0000_FFFF);
        Op_In = 3'b111; Addr_A = 5'd8; Addr_B = 5'd7; Addr_W = 5'd9;
        @(negedge clk);
        check("b2b.ready2", {31'd0, in_ready}, 32'd1);
        check("b2b.or_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b.sll_A", A, 32'd1);
        check("b2b.sll_B", B, 32'h0000_FFFF);
        check("b2b.sll_op", {29'd0, ALU_OP}, 32'd7);
        @(negedge clk);
        check("b2b.sll_done", {31'd0, done}, 32'd1);
        check_reg("b2b.r7", 5'd7, 32'h0000_FFFF);
        check_reg("b2b.r9", 5'd9, 32'h0001_FFFE);

        // 6. reset mid-EXEC aborts the op
        @(negedge clk);
        in_valid = 1'b1;
        Op_In = 3'b100; Addr_A = 5'd1; Addr_B = 5'd2; Addr_W = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort.exec", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort.done0", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("abort.done1", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort.done_after", {31'd0, done}, 32'd0);
        end
        check("abort.ready", {31'd0, in_ready}, 32'd1);
        check("abort.zf", {31'd0, Flag_ZF}, 32'd0);
        check("abort.of", {31'd0, Flag_OF}, 32'd0);
        check_reg("abort.r10", 5'd10, 32'd0);
        check_reg("abort.r1", 5'd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
